// File: rtl/alu_operand_ctrl.sv
// Execute-stage operand controller: tracks ID/EX, EX/MEM and MEM/WB destination
// records and derives operand-B select, forwarding selects and load-use stalls.
module alu_operand_ctrl #(
  parameter int REG_AW = 4,
  parameter bit FWD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              freeze,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_alu_src,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  output logic              stall,
  output logic              ex_valid,
  output logic              ex_alu_src,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              uses_rs;
    logic              uses_rt;
    logic              alu_src;
  } idex_rec_t;

  // Only the ID/EX load flag matters for hazards, so later stages keep just
  // the write-back fields.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
  } wb_rec_t;

  idex_rec_t id_ex, id_ex_d;
  wb_rec_t   ex_mem, mem_wb;

  logic idex_prod, exmem_prod, memwb_prod;
  logic id_rs_used, id_rt_used;
  logic ex_rs_used, ex_rt_used;
  logic hit_idex, hit_exmem, hit_memwb;
  logic load_use, stall_nofwd;

  // A record produces a value only when it writes a register other than R0.
  assign idex_prod  = id_ex.valid  & id_ex.reg_write  & (id_ex.rd  != '0);
  assign exmem_prod = ex_mem.valid & ex_mem.reg_write & (ex_mem.rd != '0);
  assign memwb_prod = mem_wb.valid & mem_wb.reg_write & (mem_wb.rd != '0);

  assign id_rs_used = id_valid & id_uses_rs;
  assign id_rt_used = id_valid & id_uses_rt & ~id_alu_src;
  assign ex_rs_used = id_ex.uses_rs;
  assign ex_rt_used = id_ex.uses_rt & ~id_ex.alu_src;

  assign hit_idex  = idex_prod  & ((id_rs_used & (id_rs == id_ex.rd))  |
                                   (id_rt_used & (id_rt == id_ex.rd)));
  assign hit_exmem = exmem_prod & ((id_rs_used & (id_rs == ex_mem.rd)) |
                                   (id_rt_used & (id_rt == ex_mem.rd)));
  assign hit_memwb = memwb_prod & ((id_rs_used & (id_rs == mem_wb.rd)) |
                                   (id_rt_used & (id_rt == mem_wb.rd)));

  assign load_use    = hit_idex & id_ex.mem_read;
  assign stall_nofwd = hit_idex | hit_exmem | hit_memwb;
  assign stall       = FWD_EN ? load_use : stall_nofwd;

  assign ex_valid   = id_ex.valid;
  assign ex_alu_src = id_ex.alu_src;

  // EX/MEM wins over MEM/WB because it holds the younger result.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (FWD_EN) begin
      if (exmem_prod & ex_rs_used & (ex_mem.rd == id_ex.rs))
        fwd_a = FWD_EXMEM;
      else if (memwb_prod & ex_rs_used & (mem_wb.rd == id_ex.rs))
        fwd_a = FWD_MEMWB;
      if (exmem_prod & ex_rt_used & (ex_mem.rd == id_ex.rt))
        fwd_b = FWD_EXMEM;
      else if (memwb_prod & ex_rt_used & (mem_wb.rd == id_ex.rt))
        fwd_b = FWD_MEMWB;
    end
  end

  // Bubble unless a real, non-stalled, non-flushed instruction is in ID.
  always_comb begin
    id_ex_d = '0;
    if (id_valid & ~stall & ~flush) begin
      id_ex_d.valid     = 1'b1;
      id_ex_d.rd        = id_rd;
      id_ex_d.reg_write = id_reg_write;
      id_ex_d.mem_read  = id_mem_read;
      id_ex_d.rs        = id_rs;
      id_ex_d.rt        = id_rt;
      id_ex_d.uses_rs   = id_uses_rs;
      id_ex_d.uses_rt   = id_uses_rt;
      id_ex_d.alu_src   = id_alu_src;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex  <= '0;
      ex_mem <= '0;
      mem_wb <= '0;
    end else if (!freeze) begin
      id_ex            <= id_ex_d;
      ex_mem.valid     <= id_ex.valid;
      ex_mem.rd        <= id_ex.rd;
      ex_mem.reg_write <= id_ex.reg_write;
      mem_wb           <= ex_mem;
    end
  end

endmodule

// File: tb/tb_alu_operand_ctrl.sv
// Directed bench for alu_operand_ctrl: one forwarding instance and one
// no-forwarding instance driven from the same ID-stage stimulus.
module tb_alu_operand_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       freeze, flush;
  logic       id_valid, id_uses_rs, id_uses_rt, id_alu_src;
  logic       id_reg_write, id_mem_read;
  logic [3:0] id_rs, id_rt, id_rd;

  logic       stall, ex_valid, ex_alu_src;
  logic [1:0] fwd_a, fwd_b;
  logic       nf_stall, nf_ex_valid, nf_ex_alu_src;
  logic [1:0] nf_fwd_a, nf_fwd_b;

  int n_checks = 0;
  int n_pass   = 0;

  alu_operand_ctrl #(.REG_AW(4), .FWD_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_alu_src(id_alu_src),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .stall(stall), .ex_valid(ex_valid), .ex_alu_src(ex_alu_src),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  alu_operand_ctrl #(.REG_AW(4), .FWD_EN(1'b0)) dut_nf (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_alu_src(id_alu_src),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .stall(nf_stall), .ex_valid(nf_ex_valid), .ex_alu_src(nf_ex_alu_src),
    .fwd_a(nf_fwd_a), .fwd_b(nf_fwd_b)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] rs, input logic [3:0] rt,
                       input logic urs, input logic urt, input logic asrc,
                       input logic [3:0] rd, input logic rw, input logic mr);
    id_valid     = 1'b1;
    id_rs        = rs;
    id_rt        = rt;
    id_uses_rs   = urs;
    id_uses_rt   = urt;
    id_alu_src   = asrc;
    id_rd        = rd;
    id_reg_write = rw;
    id_mem_read  = mr;
    #1;
  endtask

  task automatic idle();
    id_valid     = 1'b0;
    id_rs        = '0;
    id_rt        = '0;
    id_uses_rs   = 1'b0;
    id_uses_rt   = 1'b0;
    id_alu_src   = 1'b0;
    id_rd        = '0;
    id_reg_write = 1'b0;
    id_mem_read  = 1'b0;
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  initial begin
    rst_n  = 1'b0;
    freeze = 1'b0;
    flush  = 1'b0;
    idle();
    #10;
    check("rst_stall", {3'b0, stall}, 4'h0);
    check("rst_ex_valid", {3'b0, ex_valid}, 4'h0);
    check("rst_fwd_a", {2'b0, fwd_a}, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: LW R2 in EX, reader in ID, then async reset mid-cycle
    drive(4'd1, 4'd0, 1, 0, 0, 4'd2, 1, 1);
    tick();
    check("t1_lw_in_ex", {3'b0, ex_valid}, 4'h1);
    drive(4'd1, 4'd2, 1, 1, 0, 4'd6, 1, 0);
    check("t1_pre_rst_stall", {3'b0, stall}, 4'h1);
    rst_n = 1'b0;
    #1;
    check("t1_rst_stall", {3'b0, stall}, 4'h0);
    check("t1_rst_ex_valid", {3'b0, ex_valid}, 4'h0);
    check("t1_rst_alu_src", {3'b0, ex_alu_src}, 4'h0);
    check("t1_rst_fwd", {fwd_a, fwd_b}, 4'h0);
    rst_n = 1'b1;
    #1;
    tick();
    check("t1_first_valid", {3'b0, ex_valid}, 4'h1);
    check("t1_first_fwd", {fwd_a, fwd_b}, 4'h0);
    drain();

    // 2: ADD R3 ; SUB R4,R3,R5 -> EX/MEM forward
    drive(4'd1, 4'd2, 1, 1, 0, 4'd3, 1, 0);
    tick();
    drive(4'd3, 4'd5, 1, 1, 0, 4'd4, 1, 0);
    check("t2_no_stall", {3'b0, stall}, 4'h0);
    tick();
    check("t2_fwd_a_exmem", {2'b0, fwd_a}, 4'h2);
    check("t2_fwd_b_rf", {2'b0, fwd_b}, 4'h0);
    drain();

    // 2b: one independent instruction between -> MEM/WB forward
    drive(4'd1, 4'd2, 1, 1, 0, 4'd3, 1, 0);
    tick();
    drive(4'd9, 4'd10, 1, 1, 0, 4'd8, 1, 0);
    tick();
    drive(4'd3, 4'd5, 1, 1, 0, 4'd4, 1, 0);
    check("t2b_no_stall", {3'b0, stall}, 4'h0);
    tick();
    check("t2b_fwd_a_memwb", {2'b0, fwd_a}, 4'h1);
    check("t2b_fwd_b_rf", {2'b0, fwd_b}, 4'h0);
    drain();

    // 2c: R3 written twice back to back, read via rt -> EX/MEM has priority
    drive(4'd1, 4'd2, 1, 1, 0, 4'd3, 1, 0);
    tick();
    drive(4'd1, 4'd2, 1, 1, 0, 4'd3, 1, 0);
    tick();
    drive(4'd5, 4'd3, 1, 1, 0, 4'd4, 1, 0);
    tick();
    check("t2c_fwd_b_prio", {2'b0, fwd_b}, 4'h2);
    check("t2c_fwd_a_rf", {2'b0, fwd_a}, 4'h0);
    drain();

    // 3: LW R2 ; ADD R6,R1,R2 -> one bubble, then MEM/WB forward on B
    drive(4'd1, 4'd0, 1, 0, 0, 4'd2, 1, 1);
    tick();
    drive(4'd1, 4'd2, 1, 1, 0, 4'd6, 1, 0);
    check("t3_stall", {3'b0, stall}, 4'h1);
    tick();
    check("t3_bubble", {3'b0, ex_valid}, 4'h0);
    check("t3_stall_released", {3'b0, stall}, 4'h0);
    tick();
    idle();
    check("t3_ex_valid", {3'b0, ex_valid}, 4'h1);
    check("t3_fwd_b_memwb", {2'b0, fwd_b}, 4'h1);
    check("t3_fwd_a_rf", {2'b0, fwd_a}, 4'h0);
    check("t3_alu_src", {3'b0, ex_alu_src}, 4'h0);
    drain();

    // 4: LW R2 ; ADDI R7,R2,#5 (rt also names R2 but immediate selected)
    drive(4'd1, 4'd0, 1, 0, 0, 4'd2, 1, 1);
    tick();
    drive(4'd2, 4'd2, 1, 1, 1, 4'd7, 1, 0);
    check("t4_stall", {3'b0, stall}, 4'h1);
    tick();
    check("t4_bubble", {3'b0, ex_valid}, 4'h0);
    tick();
    idle();
    check("t4_fwd_a_memwb", {2'b0, fwd_a}, 4'h1);
    check("t4_fwd_b_imm", {2'b0, fwd_b}, 4'h0);
    check("t4_alu_src", {3'b0, ex_alu_src}, 4'h1);
    drain();

    // 4b: load to R0 never stalls or forwards
    drive(4'd1, 4'd0, 1, 0, 0, 4'd0, 1, 1);
    tick();
    drive(4'd0, 4'd0, 1, 1, 0, 4'd7, 1, 0);
    check("t4b_r0_no_stall", {3'b0, stall}, 4'h0);
    tick();
    check("t4b_r0_fwd", {fwd_a, fwd_b}, 4'h0);
    drain();

    // 4c: load dest only on rt of an immediate instruction -> no stall
    drive(4'd1, 4'd0, 1, 0, 0, 4'd2, 1, 1);
    tick();
    drive(4'd1, 4'd2, 1, 1, 1, 4'd7, 1, 0);
    check("t4c_imm_rt_no_stall", {3'b0, stall}, 4'h0);
    drain();

    // 5: load-use stall coincident with flush -> bubble, reader not issued
    drive(4'd1, 4'd0, 1, 0, 0, 4'd2, 1, 1);
    tick();
    drive(4'd1, 4'd2, 1, 1, 0, 4'd6, 1, 0);
    flush = 1'b1;
    #1;
    check("t5_flush_stall", {3'b0, stall}, 4'h1);
    tick();
    flush = 1'b0;
    idle();
    check("t5_flush_bubble", {3'b0, ex_valid}, 4'h0);
    tick();
    check("t5_no_dup", {3'b0, ex_valid}, 4'h0);
    drain();

    // 5b: freeze held 4 cycles during a load-use stall
    drive(4'd1, 4'd0, 1, 0, 0, 4'd2, 1, 1);
    tick();
    drive(4'd1, 4'd2, 1, 1, 0, 4'd6, 1, 0);
    freeze = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5b_frz_stall", {3'b0, stall}, 4'h1);
      check("t5b_frz_ex_valid", {3'b0, ex_valid}, 4'h1);
    end
    freeze = 1'b0;
    #1;
    tick();
    check("t5b_bubble", {3'b0, ex_valid}, 4'h0);
    check("t5b_released", {3'b0, stall}, 4'h0);
    tick();
    idle();
    check("t5b_ex_valid", {3'b0, ex_valid}, 4'h1);
    check("t5b_fwd_b_memwb", {2'b0, fwd_b}, 4'h1);
    drain();

    // 6: no-forwarding instance, ADD R3 then back-to-back reader
    drive(4'd1, 4'd2, 1, 1, 0, 4'd3, 1, 0);
    check("t6_nf_no_stall_first", {3'b0, nf_stall}, 4'h0);
    tick();
    drive(4'd3, 4'd5, 1, 1, 0, 4'd4, 1, 0);
    check("t6_fwd_inst_no_stall", {3'b0, stall}, 4'h0);
    for (int i = 0; i < 3; i++) begin
      check("t6_nf_stall", {3'b0, nf_stall}, 4'h1);
      check("t6_nf_fwd", {nf_fwd_a, nf_fwd_b}, 4'h0);
      tick();
    end
    check("t6_nf_release", {3'b0, nf_stall}, 4'h0);
    check("t6_nf_bubble", {3'b0, nf_ex_valid}, 4'h0);
    tick();
    idle();
    check("t6_nf_reader_in_ex", {3'b0, nf_ex_valid}, 4'h1);
    check("t6_nf_reader_fwd", {nf_fwd_a, nf_fwd_b}, 4'h0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
